mem_bank_scheduler: RTL and testbench

- Controller for the multi-bank operator/channel state memory (NUM_BANKS banks × DEPTH words, one write port, one read port, registered read with OUTPUT_DELAY).
- Runs the per-sample read sweep over every bank/address in order.
- Arbitrates the single write port between the operator pipeline writeback (highest priority, never stalls) and host register writes (valid/ready, one-entry holding register).
- Sits between the host register interface/operator pipeline and the memory instance.

---
 rtl/mem_bank_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bank_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_scheduler.sv
// Read-sweep sequencer and single-write-port arbiter for the banked state memory.
// Pipeline writebacks always win the write port; host writes wait in a one-entry holding register.
`timescale 1ns/1ps
module mem_bank_scheduler #(
  parameter int NUM_BANKS    = 2,
  parameter int DEPTH        = 18,
  parameter int OUTPUT_DELAY = 1,
  parameter int DATA_WIDTH   = 8,
  parameter int BANK_WIDTH   = $clog2(NUM_BANKS),
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_start,
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic                  sweep_overrun,
  output logic                  mem_reb,
  output logic [BANK_WIDTH-1:0] mem_bankb,
  output logic [ADDR_WIDTH-1:0] mem_addrb,
  output logic                  rd_valid,
  output logic [BANK_WIDTH-1:0] rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wb_valid,
  input  logic [BANK_WIDTH-1:0] wb_bank,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [BANK_WIDTH-1:0] host_bank,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  mem_wea,
  output logic [BANK_WIDTH-1:0] mem_banka,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dia
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  localparam logic [BANK_WIDTH-1:0] LAST_BANK  = BANK_WIDTH'(NUM_BANKS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [1:0]            DRAIN_INIT = 2'(OUTPUT_DELAY);

  state_t                  state, state_next;
  logic [1:0]              drain_cnt, drain_cnt_next;
  logic                    reb_next;
  logic [BANK_WIDTH-1:0]   bankb_next;
  logic [ADDR_WIDTH-1:0]   addrb_next;
  logic                    drain_last;

  logic                    hold_valid;
  logic [BANK_WIDTH-1:0]   hold_bank;
  logic [ADDR_WIDTH-1:0]   hold_addr;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    host_accept;

  assign drain_last = (state == DRAIN) && (drain_cnt == 2'd0);

  // Sweep state register; the read command registers double as the sweep position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= 2'd0;
      mem_reb   <= 1'b0;
      mem_bankb <= '0;
      mem_addrb <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      mem_reb   <= reb_next;
      mem_bankb <= bankb_next;
      mem_addrb <= addrb_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    reb_next       = 1'b0;
    bankb_next     = mem_bankb;
    addrb_next     = mem_addrb;
    case (state)
      IDLE: begin
        if (sample_start) begin
          state_next = SWEEP;
          reb_next   = 1'b1;
          bankb_next = '0;
          addrb_next = '0;
        end
      end
      SWEEP: begin
        if (mem_bankb == LAST_BANK && mem_addrb == LAST_ADDR) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_INIT;
        end else begin
          reb_next = 1'b1;
          // Address wraps at the bank depth, which need not be a power of two.
          if (mem_addrb == LAST_ADDR) begin
            addrb_next = '0;
            bankb_next = mem_bankb + BANK_WIDTH'(1);
          end else begin
            addrb_next = mem_addrb + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd0) begin
          if (sample_start) begin
            state_next = SWEEP;
            reb_next   = 1'b1;
            bankb_next = '0;
            addrb_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          drain_cnt_next = drain_cnt - 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sweep_busy    = (state != IDLE);
    sweep_done    = !reset && drain_last;
    sweep_overrun = !reset && sample_start && (state != IDLE) && !drain_last;
  end

  // Read tag alignment stage: tags follow the command by the memory latency.
  generate
    if (OUTPUT_DELAY == 0) begin : g_tag_comb
      assign rd_valid = mem_reb;
      assign rd_bank  = mem_bankb;
      assign rd_addr  = mem_addrb;
    end else begin : g_tag_pipe
      logic                  vld_p  [OUTPUT_DELAY];
      logic [BANK_WIDTH-1:0] bank_p [OUTPUT_DELAY];
      logic [ADDR_WIDTH-1:0] addr_p [OUTPUT_DELAY];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < OUTPUT_DELAY; i++) begin
            vld_p[i]  <= 1'b0;
            bank_p[i] <= '0;
            addr_p[i] <= '0;
          end
        end else begin
          vld_p[0]  <= mem_reb;
          bank_p[0] <= mem_bankb;
          addr_p[0] <= mem_addrb;
          for (int i = 1; i < OUTPUT_DELAY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            bank_p[i] <= bank_p[i-1];
            addr_p[i] <= addr_p[i-1];
          end
        end
      end
      assign rd_valid = vld_p[OUTPUT_DELAY-1];
      assign rd_bank  = bank_p[OUTPUT_DELAY-1];
      assign rd_addr  = addr_p[OUTPUT_DELAY-1];
    end
  endgenerate

  // The hold slot can always refill when it is empty or about to drain this cycle.
  assign host_ready  = !reset && (!hold_valid || !wb_valid);
  assign host_accept = host_valid && host_ready;

  // Write port stage: writeback first, held host write whenever writeback is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      mem_wea    <= 1'b0;
      mem_banka  <= '0;
      mem_addra  <= '0;
      mem_dia    <= '0;
    end else begin
      hold_valid <= host_accept || (hold_valid && wb_valid);
      if (wb_valid) begin
        mem_wea   <= 1'b1;
        mem_banka <= wb_bank;
        mem_addra <= wb_addr;
        mem_dia   <= wb_data;
      end else if (hold_valid) begin
        mem_wea   <= 1'b1;
        mem_banka <= hold_bank;
        mem_addra <= hold_addr;
        mem_dia   <= hold_data;
      end else begin
        mem_wea   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (host_accept) begin
      hold_bank <= host_bank;
      hold_addr <= host_addr;
      hold_data <= host_data;
    end
  end

endmodule

// File: tb/tb_mem_bank_scheduler.sv
// Bench for mem_bank_scheduler: scoreboards for read commands, read tags and writes,
// a vector table for write arbitration, and hand sequences for sweep and reset corners.
`timescale 1ns/1ps
module tb_mem_bank_scheduler;

  localparam int NB = 2;
  localparam int DP = 18;
  localparam int BW = 1;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_start = 1'b0;
  logic          sweep_busy, sweep_done, sweep_overrun;
  logic          mem_reb;
  logic [BW-1:0] mem_bankb;
  logic [AW-1:0] mem_addrb;
  logic          rd_valid;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;
  logic          wb_valid = 1'b0;
  logic [BW-1:0] wb_bank = '0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [BW-1:0] host_bank = '0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          mem_wea;
  logic [BW-1:0] mem_banka;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dia;

  mem_bank_scheduler #(
    .NUM_BANKS(NB), .DEPTH(DP), .OUTPUT_DELAY(1), .DATA_WIDTH(DW),
    .BANK_WIDTH(BW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .sample_start(sample_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_overrun(sweep_overrun),
    .mem_reb(mem_reb), .mem_bankb(mem_bankb), .mem_addrb(mem_addrb),
    .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .wb_valid(wb_valid), .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_bank(host_bank),
    .host_addr(host_addr), .host_data(host_data),
    .mem_wea(mem_wea), .mem_banka(mem_banka), .mem_addra(mem_addra), .mem_dia(mem_dia)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            at;
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t reb_q[$];
  exp_t rd_q[$];
  exp_t wr_q[$];

  logic [DW-1:0] tbmem [NB][DP];
  logic          chk_rb = 1'b0;

  function automatic logic [63:0] pack(input int at, input logic [BW-1:0] b,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {8'h0, at[31:0], 3'b0, b, 3'b0, a, d};
  endfunction

  task automatic push_sweep(input int base, input int nreb, input int nrd);
    exp_t e;
    for (int k = 0; k < nreb; k++) begin
      e.at = base + 1 + k; e.bank = BW'(k / DP); e.addr = AW'(k % DP); e.data = '0;
      reb_q.push_back(e);
    end
    for (int k = 0; k < nrd; k++) begin
      e.at = base + 2 + k; e.bank = BW'(k / DP); e.addr = AW'(k % DP); e.data = '0;
      rd_q.push_back(e);
    end
  endtask

  task automatic push_wr(input int at, input logic [BW-1:0] b, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    exp_t e;
    e.at = at; e.bank = b; e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  // Output monitors: every read command, read tag and write is popped against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (mem_reb === 1'b1) begin
      if (reb_q.size() == 0) check("reb_unexpected", pack(cyc, mem_bankb, mem_addrb, 0), 64'h0);
      else begin
        e = reb_q.pop_front();
        check("reb_tag", pack(cyc, mem_bankb, mem_addrb, 0), pack(e.at, e.bank, e.addr, 0));
      end
    end
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) check("rd_unexpected", pack(cyc, rd_bank, rd_addr, 0), 64'h0);
      else begin
        e = rd_q.pop_front();
        check("rd_tag", pack(cyc, rd_bank, rd_addr, 0), pack(e.at, e.bank, e.addr, 0));
      end
      if (chk_rb && rd_bank == 1'b0 && rd_addr == 5'd7)
        check("readback_b0_a7", 64'(tbmem[0][7]), 64'h33);
    end
    if (mem_wea === 1'b1) begin
      if (mem_addra < AW'(DP)) tbmem[mem_banka][mem_addra] = mem_dia;
      if (wr_q.size() == 0) check("wr_unexpected", pack(cyc, mem_banka, mem_addra, mem_dia), 64'h0);
      else begin
        e = wr_q.pop_front();
        check("wr", pack(cyc, mem_banka, mem_addra, mem_dia), pack(e.at, e.bank, e.addr, e.data));
      end
    end
  end

  typedef struct {
    logic          wv;
    logic [BW-1:0] wbk;
    logic [AW-1:0] wad;
    logic [DW-1:0] wd;
    logic          hv;
    logic [BW-1:0] hbk;
    logic [AW-1:0] had;
    logic [DW-1:0] hd;
    logic          rdy;
    logic          ew;
    logic [BW-1:0] ebk;
    logic [AW-1:0] ead;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic wv, input int wbk, input int wad, input int wd,
                      input logic hv, input int hbk, input int had, input int hd,
                      input logic rdy, input logic ew, input int ebk, input int ead, input int ed);
    vec_t v;
    v.wv = wv; v.wbk = BW'(wbk); v.wad = AW'(wad); v.wd = DW'(wd);
    v.hv = hv; v.hbk = BW'(hbk); v.had = AW'(had); v.hd = DW'(hd);
    v.rdy = rdy; v.ew = ew; v.ebk = BW'(ebk); v.ead = AW'(ead); v.ed = DW'(ed);
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DP; a++) tbmem[b][a] = '0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
    end
    check("rst_mem_reb", 64'(mem_reb), 64'h0);
    check("rst_mem_wea", 64'(mem_wea), 64'h0);
    check("rst_rd_valid", 64'(rd_valid), 64'h0);
    check("rst_flags", {61'h0, sweep_busy, sweep_done, sweep_overrun}, 64'h0);
    check("rst_host_ready", 64'(host_ready), 64'h0);
    check("rst_wr_fields", {40'h0, 3'b0, mem_banka, 3'b0, mem_addra, mem_dia}, 64'h0);
    step();
    reset = 1'b0;
    sample();
    check("host_ready_after_reset", 64'(host_ready), 64'h1);

    // Full sweep: reads on cycles 1..36, tags 2..37, done at 38
    step();
    t0 = cyc;
    sample_start = 1'b1;
    push_sweep(t0, NB * DP, NB * DP);
    sample();
    check("busy_at_start", 64'(sweep_busy), 64'h0);
    for (int r = 1; r <= 39; r++) begin
      step();
      sample_start = 1'b0;
      sample();
      check("sweep1_busy", 64'(sweep_busy), 64'(r <= 38));
      check("sweep1_done", 64'(sweep_done), 64'(r == 38));
    end
    check("sweep1_reb_q_empty", 64'(reb_q.size()), 64'h0);
    check("sweep1_rd_q_empty", 64'(rd_q.size()), 64'h0);

    // Overrun at 10, restart coincident with sweep_done
    step();
    t0 = cyc;
    sample_start = 1'b1;
    push_sweep(t0, NB * DP, NB * DP);
    sample();
    for (int r = 1; r <= 38; r++) begin
      step();
      sample_start = (r == 10 || r == 38);
      if (r == 38) push_sweep(cyc, NB * DP, NB * DP);
      sample();
      check("sweep2_overrun", 64'(sweep_overrun), 64'(r == 10));
      if (r == 38) check("sweep2_done_with_start", 64'(sweep_done), 64'h1);
    end
    for (int r = 1; r <= 39; r++) begin
      step();
      sample_start = 1'b0;
      sample();
      check("sweep3_done", 64'(sweep_done), 64'(r == 38));
      check("sweep3_overrun", 64'(sweep_overrun), 64'h0);
    end
    check("sweep3_reb_q_empty", 64'(reb_q.size()), 64'h0);
    check("sweep3_rd_q_empty", 64'(rd_q.size()), 64'h0);

    // Write arbitration table: inputs this cycle, host_ready this cycle, write seen this cycle
    addv(1,0,3,'h11, 1,1,5,'hA5, 1, 0,0,0,0);
    for (int i = 0; i < 4; i++) addv(1,0,3,'h11, 0,0,0,0, 0, 1,0,3,'h11);
    addv(0,0,0,0, 0,0,0,0, 1, 1,0,3,'h11);
    addv(0,0,0,0, 0,0,0,0, 1, 1,1,5,'hA5);
    addv(0,0,0,0, 0,0,0,0, 1, 0,0,0,0);
    addv(0,0,0,0, 1,0,1,'h01, 1, 0,0,0,0);
    addv(0,0,0,0, 1,0,2,'h02, 1, 0,0,0,0);
    addv(0,0,0,0, 1,0,3,'h03, 1, 1,0,1,'h01);
    addv(0,0,0,0, 1,0,4,'h04, 1, 1,0,2,'h02);
    addv(0,0,0,0, 0,0,0,0, 1, 1,0,3,'h03);
    addv(0,0,0,0, 0,0,0,0, 1, 1,0,4,'h04);
    addv(0,0,0,0, 0,0,0,0, 1, 0,0,0,0);
    addv(1,0,7,'h22, 1,0,7,'h33, 1, 0,0,0,0);
    addv(0,0,0,0, 0,0,0,0, 1, 1,0,7,'h22);
    addv(0,0,0,0, 0,0,0,0, 1, 1,0,7,'h33);
    addv(0,0,0,0, 0,0,0,0, 1, 0,0,0,0);
    addv(1,1,0,'hAA, 1,1,1,'h44, 1, 0,0,0,0);
    addv(1,1,0,'hAB, 1,1,2,'h55, 0, 1,1,0,'hAA);
    addv(1,1,0,'hAC, 1,1,2,'h55, 0, 1,1,0,'hAB);
    addv(0,0,0,0, 1,1,2,'h55, 1, 1,1,0,'hAC);
    addv(0,0,0,0, 0,0,0,0, 1, 1,1,1,'h44);
    addv(0,0,0,0, 0,0,0,0, 1, 1,1,2,'h55);
    addv(0,0,0,0, 0,0,0,0, 1, 0,0,0,0);
    foreach (vecs[i]) begin
      step();
      wb_valid = vecs[i].wv; wb_bank = vecs[i].wbk; wb_addr = vecs[i].wad; wb_data = vecs[i].wd;
      host_valid = vecs[i].hv; host_bank = vecs[i].hbk; host_addr = vecs[i].had;
      host_data = vecs[i].hd;
      if (vecs[i].ew) push_wr(cyc, vecs[i].ebk, vecs[i].ead, vecs[i].ed);
      sample();
      check($sformatf("vec%0d_host_ready", i), 64'(host_ready), 64'(vecs[i].rdy));
    end
    check("table_wr_q_empty", 64'(wr_q.size()), 64'h0);

    // Readback sweep: the host value written after the writeback must be the final one
    step();
    t0 = cyc;
    sample_start = 1'b1;
    chk_rb = 1'b1;
    push_sweep(t0, NB * DP, NB * DP);
    for (int r = 1; r <= 39; r++) begin
      step();
      sample_start = 1'b0;
    end
    chk_rb = 1'b0;
    check("rb_rd_q_empty", 64'(rd_q.size()), 64'h0);

    // Reset at cycle 20 of a sweep with the hold register full
    step();
    t0 = cyc;
    sample_start = 1'b1;
    push_sweep(t0, 20, 19);
    sample();
    for (int r = 1; r <= 45; r++) begin
      step();
      sample_start = 1'b0;
      wb_valid = (r >= 18 && r <= 20);
      wb_bank = 1'b0; wb_addr = 5'd9; wb_data = 8'h5A;
      host_valid = (r == 18);
      host_bank = 1'b1; host_addr = 5'd9; host_data = 8'h77;
      reset = (r == 20 || r == 21);
      if (r == 19 || r == 20) push_wr(cyc, 1'b0, 5'd9, 8'h5A);
      sample();
      if (r == 18) check("rst6_ready_empty_hold", 64'(host_ready), 64'h1);
      if (r == 19) check("rst6_ready_full_hold", 64'(host_ready), 64'h0);
      if (r == 21) begin
        check("rst6_reb", 64'(mem_reb), 64'h0);
        check("rst6_wea", 64'(mem_wea), 64'h0);
        check("rst6_rd_valid", 64'(rd_valid), 64'h0);
        check("rst6_busy", 64'(sweep_busy), 64'h0);
        check("rst6_fields", {40'h0, 3'b0, mem_bankb, 3'b0, mem_addrb, mem_dia}, 64'h0);
      end
      if (r == 22) check("rst6_ready_after", 64'(host_ready), 64'h1);
      check("rst6_no_done", 64'(sweep_done), 64'h0);
    end
    check("rst6_reb_q_empty", 64'(reb_q.size()), 64'h0);
    check("rst6_rd_q_empty", 64'(rd_q.size()), 64'h0);
    check("rst6_wr_q_empty", 64'(wr_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
